serial_compare_scheduler: RTL
=============================

// Module: serial_compare_scheduler
// PURPOSE
//  Shares one MSB-first serial comparator core between N_REQ requesters.
//  - Accepts parallel operand pairs via valid/ready and arbitrates round-robin.
//  - Shifts the granted pair MSB-first into the core, then returns a registered less/eq/greater result tagged with the requester id.
//  - Sits between parallel producers and the bit-serial compare datapath.
// PARAMETERS
//  W      8  operand width in bits (>=2)
//  N_REQ  2  number of requesters (>=2); ID_W = $clog2(N_REQ)
// PORTS
//  clk          in   1          single clock, rising edge
//  rst_n        in   1          asynchronous active-low reset
//  req_valid    in   N_REQ      requester i has an operand pair
//  req_ready    out  N_REQ      one-hot grant; handshake when valid&ready
//  req_a        in   N_REQ*W    operand A, requester i at [i*W +: W]
//  req_b        in   N_REQ*W    operand B, same packing
//  res_valid    out  1          result available; held until accepted
//  res_ready    in   1          consumer accepts result
//  res_id       out  ID_W       requester index of the result
//  res_less     out  1          A < B (unsigned)
//  res_eq       out  1          A == B
//  res_greater  out  1          A > B; exactly one of less/eq/greater is 1 while res_valid
//  busy         out  1          state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all outputs 0; shift regs 0; rr pointer=N_REQ-1, so requester 0 wins first.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: req_ready = one-hot of the first valid requester after the rr pointer (combinational from req_valid); 0 if none valid.
//    On handshake (cycle T): capture a/b into shift regs, latch id, clear the core, set bit_cnt=W-1, update rr pointer=id, go SHIFT.
//  - SHIFT: each cycle present sh_a[W-1], sh_b[W-1] to the core, then shift both regs left by 1 and decrement bit_cnt.
//    On bit_cnt==0, register the core outputs into res_* and go DONE.
//  - DONE: res_valid=1; res_* stay stable until res_valid&res_ready, then return to IDLE.
//    req_ready=0 throughout SHIFT and DONE.
//  - Latency: handshake at T -> res_valid at T+W+1. Throughput is one compare per W+2 cycles with res_ready tied high.
//  - Core semantics: eq=prev_eq&(a==b); the first differing bit fixes gt/lt; the decision is sticky for the rest of the word.
//  - Simultaneous events:
//    - A request arriving in DONE is not accepted in the same cycle as result acceptance; it is taken in the next IDLE cycle.
//    - req_valid dropping without a handshake is legal and is ignored.
//  - Reset mid-operation: the in-flight compare is discarded with no result; the rr pointer returns to its reset value.
//  - No wrap hazards: bit_cnt is a $clog2(W)-bit down-counter that never underflows (it leaves SHIFT at 0).
// CONFIGURATION
//  SERIAL_CMP_EARLY_EXIT_EN
//  - Defined: SHIFT also exits as soon as the core reports non-equal.
//    Result at T+k+1, where k = 1-based position of the first differing bit from the MSB.
//    Equal operands still take W cycles.
//  - Undefined: always W shift cycles, with fixed latency W+1.
//  Result values are identical in both builds; only timing differs.
// STRUCTURE
//  - Package serial_cmp_pkg:
//    - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sched_state_t
//    - typedef struct packed {less, eq, greater} cmp_res_t
//    - localparam CMP_RES_EQ = '{0,1,0}
//  - Sub-module serial_cmp_msb_core: inputs clk, rst_n, clear, en, a, b; outputs cmp_res_t (combinational from sticky prev_eq/prev_gt regs).
//  - Top contains the FSM, round-robin arbiter, shift regs and result regs.
// TESTING (W=8, N_REQ=2, res_ready=1 unless stated)
//  1. req0 A=0x5A B=0x5A at T -> res_valid at T+9, res_eq=1, res_id=0.
//  2. req1 A=0x80 B=0x7F -> res_greater=1, res_id=1. Valid at T+9 without the macro, T+2 with SERIAL_CMP_EARLY_EXIT_EN.
//  3. req0 A=0x00 B=0xFF -> res_less=1 and exactly one flag set; A=0x01 B=0x00 -> res_greater=1 at T+9 in both builds.
//  4. Both requesters valid continuously after reset -> grants alternate 0,1,0,1; req_ready never multi-hot.
//  5. res_ready=0 for 5 cycles in DONE -> res_* stable, busy=1, req_ready=0; accepted on the 6th cycle, IDLE on the next.
//  6. rst_n=0 for 1 cycle mid-SHIFT -> outputs 0 immediately (async); the next request A=0x3C B=0x3D yields res_less=1 with no stale result.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Package: serial_cmp_pkg
// Shared types for the serial compare scheduler.
//   sched_state_t : scheduler FSM states (IDLE -> SHIFT -> DONE -> IDLE)
//   cmp_res_t     : one-hot {less, eq, greater} comparison result
//   CMP_RES_EQ    : result value of a comparison with no differing bits yet
//   cmp_from_flags: builds a cmp_res_t from the sticky eq / greater flags
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic less;
        logic eq;
        logic greater;
    } cmp_res_t;

    localparam cmp_res_t CMP_RES_EQ = '{less: 1'b0, eq: 1'b1, greater: 1'b0};

    // The core only tracks "still equal" and "greater"; less is whatever is left.
    function automatic cmp_res_t cmp_from_flags(input logic eq, input logic gt);
        cmp_res_t r;
        r.less    = ~eq & ~gt;
        r.eq      = eq;
        r.greater = gt;
        return r;
    endfunction

endpackage

// File: rtl/serial_cmp_msb_core.sv
// Module: serial_cmp_msb_core
// MSB-first bit-serial unsigned comparator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart a new word (back to "equal so far")
//   en         : a and b carry a valid bit this cycle
//   a, b       : current operand bits, most significant first
//   res        : result including the bit presented this cycle
module serial_cmp_msb_core
    import serial_cmp_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clear,
    input  logic     en,
    input  logic     a,
    input  logic     b,
    output cmp_res_t res
);

    logic prev_eq;
    logic prev_gt;
    logic eq_now;
    logic gt_now;

    // The result already folds in the current bit so the scheduler can
    // register the final answer on the same edge that consumes the last bit.
    // Once a difference is seen prev_eq drops and the decision is frozen.
    always_comb begin
        eq_now = prev_eq;
        gt_now = prev_gt;
        if (en) begin
            eq_now = prev_eq & (a == b);
            gt_now = prev_gt | (prev_eq & a & ~b);
        end
        res = cmp_from_flags(eq_now, gt_now);
    end

    // Sticky decision registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_eq <= CMP_RES_EQ.eq;
            prev_gt <= CMP_RES_EQ.greater;
        end else if (clear) begin
            prev_eq <= CMP_RES_EQ.eq;
            prev_gt <= CMP_RES_EQ.greater;
        end else if (en) begin
            prev_eq <= eq_now;
            prev_gt <= gt_now;
        end
    end

endmodule

// File: rtl/serial_compare_scheduler.sv
// Module: serial_compare_scheduler
// Shares one MSB-first serial comparator between N_REQ requesters with
// round-robin arbitration and returns a registered, id-tagged result.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake, req_ready is a one-hot grant
//   req_a, req_b        : packed operands, requester i at [i*W +: W]
//   res_valid/res_ready : result handshake, result held until accepted
//   res_id              : requester index of the result
//   res_less/eq/greater : unsigned comparison result (exactly one set)
//   busy                : scheduler not in IDLE
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to leave SHIFT as soon as the
// operands are known to differ; results are identical, only latency changes.
module serial_compare_scheduler
    import serial_cmp_pkg::*;
#(
    parameter int W     = 8,
    parameter int N_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*W-1:0]         req_a,
    input  logic [N_REQ*W-1:0]         req_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    output logic                       res_less,
    output logic                       res_eq,
    output logic                       res_greater,
    output logic                       busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(W);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    sched_state_t state;
    sched_state_t state_nxt;

    logic [W-1:0]     op_a [N_REQ];
    logic [W-1:0]     op_b [N_REQ];
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_found;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  cur_id;
    logic [W-1:0]     sh_a;
    logic [W-1:0]     sh_b;
    logic [CNT_W-1:0] bit_cnt;
    logic             handshake;
    logic             shift_last;
    cmp_res_t         core_res;

    // Unpack the flat operand buses so the arbiter can index by requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = req_a[i*W +: W];
            op_b[i] = req_b[i*W +: W];
        end
    end

    // Round-robin search starts just after the last winner, so the requester
    // that was served most recently has the lowest priority.
    always_comb begin
        logic [ID_W-1:0] idx;
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = ID_W'((int'(rr_ptr) + off) % N_REQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign handshake  = (state == IDLE) && grant_found;
    assign shift_last = (bit_cnt == '0) || (EARLY_EXIT && !core_res.eq);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_found) state_nxt = SHIFT;
            SHIFT:   if (shift_last)  state_nxt = DONE;
            DONE:    if (res_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; grants are only offered while IDLE.
    always_comb begin
        req_ready = '0;
        busy      = 1'b1;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = grant;
                busy      = 1'b0;
            end
            SHIFT: begin
                busy = 1'b1;
            end
            DONE: begin
                res_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Operand capture, shifting and result registers. The result is
    // cleared once accepted so the flags are only ever set alongside res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a        <= '0;
            sh_b        <= '0;
            bit_cnt     <= '0;
            cur_id      <= '0;
            rr_ptr      <= ID_W'(N_REQ - 1);
            res_id      <= '0;
            res_less    <= 1'b0;
            res_eq      <= 1'b0;
            res_greater <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        sh_a    <= op_a[grant_id];
                        sh_b    <= op_b[grant_id];
                        cur_id  <= grant_id;
                        rr_ptr  <= grant_id;
                        bit_cnt <= CNT_W'(W - 1);
                    end
                end
                SHIFT: begin
                    sh_a <= sh_a << 1;
                    sh_b <= sh_b << 1;
                    if (shift_last) begin
                        res_id      <= cur_id;
                        res_less    <= core_res.less;
                        res_eq      <= core_res.eq;
                        res_greater <= core_res.greater;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_id      <= '0;
                        res_less    <= 1'b0;
                        res_eq      <= 1'b0;
                        res_greater <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    serial_cmp_msb_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (handshake),
        .en    (state == SHIFT),
        .a     (sh_a[W-1]),
        .b     (sh_b[W-1]),
        .res   (core_res)
    );

endmodule
